// File: rtl/float_aligner.sv
// Pre-add operand alignment for the binary32 adder.
// Orders two operands by magnitude and right-shifts the smaller 27-bit
// fraction {hidden, mant, G, R, S} until its exponent matches the larger one.
// The shift runs iteratively, STEP bits per cycle, and bit0 accumulates sticky.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// in_ready is high only in IDLE; out_valid is high only in DONE. While
// out_valid is high and out_ready is low, every output is held stable.
// There is no bypass: a new operand pair is never accepted on the same
// edge that completes the output handshake.
module float_aligner #(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [26:0] bigFract,
    output logic [26:0] smallFract,
    output logic [7:0]  expAligned,
    output logic        bigSign,
    output logic        diferenSigns,
    output logic        special,
    output logic [1:0]  stateDbg
);
    localparam int FRACT_W = 27;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CMP   = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [7:0] STEP_SZ = 8'(STEP);
    localparam logic [7:0] FULL_SHIFT = 8'(FRACT_W);

    logic [1:0]         state;
    logic [31:0]        latA;
    logic [31:0]        latB;
    logic [7:0]         cnt;

    logic [7:0]         effExpA, effExpB;
    logic [FRACT_W-1:0] fractA, fractB;
    logic               aBig;
    logic [7:0]         bigEff, smallEff;
    logic [FRACT_W-1:0] bigF, smallF;
    logic [7:0]         shiftAmt;
    logic [FRACT_W-1:0] lostMask;
    logic [FRACT_W-1:0] shiftedSmall;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign stateDbg  = state;

    // Unpack latched operands, pick the larger magnitude, and form one shift step.
    always_comb begin
        effExpA      = (latA[30:23] == 8'h00) ? 8'h01 : latA[30:23];
        effExpB      = (latB[30:23] == 8'h00) ? 8'h01 : latB[30:23];
        fractA       = {(latA[30:23] != 8'h00), latA[22:0], 3'b000};
        fractB       = {(latB[30:23] != 8'h00), latB[22:0], 3'b000};
        // Equal magnitude keeps A as the big operand.
        aBig         = ({effExpA, fractA} >= {effExpB, fractB});
        bigEff       = aBig ? effExpA : effExpB;
        smallEff     = aBig ? effExpB : effExpA;
        bigF         = aBig ? fractA : fractB;
        smallF       = aBig ? fractB : fractA;
        shiftAmt     = (cnt < STEP_SZ) ? cnt : STEP_SZ;
        lostMask     = ~({FRACT_W{1'b1}} << shiftAmt);
        shiftedSmall = (smallFract >> shiftAmt)
                     | {{(FRACT_W-1){1'b0}}, |(smallFract & lostMask)};
    end

    // FSM plus all datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            latA         <= '0;
            latB         <= '0;
            cnt          <= '0;
            bigFract     <= '0;
            smallFract   <= '0;
            expAligned   <= '0;
            bigSign      <= 1'b0;
            diferenSigns <= 1'b0;
            special      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        latA  <= opA;
                        latB  <= opB;
                        state <= CMP;
                    end
                end
                CMP: begin
                    bigFract     <= bigF;
                    smallFract   <= smallF;
                    expAligned   <= (bigF == '0) ? 8'h00 : bigEff;
                    bigSign      <= aBig ? latA[31] : latB[31];
                    diferenSigns <= latA[31] ^ latB[31];
                    special      <= (latA[30:23] == 8'hFF) || (latB[30:23] == 8'hFF);
                    cnt          <= bigEff - smallEff;
                    state        <= (bigEff == smallEff) ? DONE : SHIFT;
                end
                SHIFT: begin
                    if (cnt >= FULL_SHIFT) begin
                        // Everything falls off the end: only sticky survives.
                        smallFract <= {{(FRACT_W-1){1'b0}}, |smallFract};
                        cnt        <= '0;
                        state      <= DONE;
                    end else begin
                        smallFract <= shiftedSmall;
                        cnt        <= cnt - shiftAmt;
                        if (cnt == shiftAmt) begin
                            state <= DONE;
                        end
                    end
                end
                default: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_float_aligner.sv
// Directed bench for float_aligner: STEP=1 main instance plus a STEP=4 instance.
module tb_float_aligner;
    logic        clk;
    logic        rst_n;
    logic        inValid, inReady, outValid, outReady;
    logic [31:0] opA, opB;
    logic [26:0] bigFract, smallFract;
    logic [7:0]  expAligned;
    logic        bigSign, diferenSigns, special;
    logic [1:0]  stateDbg;

    logic        inValid4, inReady4, outValid4, outReady4;
    logic [31:0] opA4, opB4;
    logic [26:0] bigFract4, smallFract4;
    logic [7:0]  expAligned4;
    logic        bigSign4, diferenSigns4, special4;
    logic [1:0]  stateDbg4;

    int nCompared;
    int nMismatched;

    float_aligner #(.STEP(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady),
        .opA(opA), .opB(opB), .out_valid(outValid), .out_ready(outReady),
        .bigFract(bigFract), .smallFract(smallFract), .expAligned(expAligned),
        .bigSign(bigSign), .diferenSigns(diferenSigns), .special(special),
        .stateDbg(stateDbg)
    );

    float_aligner #(.STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid4), .in_ready(inReady4),
        .opA(opA4), .opB(opB4), .out_valid(outValid4), .out_ready(outReady4),
        .bigFract(bigFract4), .smallFract(smallFract4), .expAligned(expAligned4),
        .bigSign(bigSign4), .diferenSigns(diferenSigns4), .special(special4),
        .stateDbg(stateDbg4)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: present an operand pair and count edges (accept edge = 1) until out_valid.
    task automatic runOp(input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clk);
        opA = a;
        opB = b;
        inValid = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            if (lat == 0) inValid = 1'b0;
            lat++;
        end while (!outValid && lat < 100);
    endtask

    task automatic runOp4(input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clk);
        opA4 = a;
        opB4 = b;
        inValid4 = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            if (lat == 0) inValid4 = 1'b0;
            lat++;
        end while (!outValid4 && lat < 100);
    endtask

    // Driver: complete the output handshake on one edge.
    task automatic releaseOp();
        @(negedge clk);
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        nCompared++;
        if (inReady !== 1'b1 || outValid !== 1'b0) begin
            nMismatched++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", inReady, outValid);
        end
        nCompared++;
        if (bigFract !== 27'h0 || smallFract !== 27'h0 || expAligned !== 8'h0 || special !== 1'b0) begin
            nMismatched++;
            $display("FAIL reset_regs: big=%h small=%h exp=%h sp=%b required zeros",
                     bigFract, smallFract, expAligned, special);
        end
        nCompared++;
        if (inReady4 !== 1'b1 || outValid4 !== 1'b0) begin
            nMismatched++;
            $display("FAIL reset_hs4: in_ready=%b out_valid=%b required 1/0", inReady4, outValid4);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_equal();
        int lat;
        runOp(32'h3F800000, 32'h3F800000, lat);
        nCompared++;
        if (lat !== 2) begin
            nMismatched++;
            $display("FAIL equal_lat: got %0d required 2", lat);
        end
        nCompared++;
        if (bigFract !== 27'h4000000 || smallFract !== 27'h4000000 || expAligned !== 8'h7F
            || diferenSigns !== 1'b0) begin
            nMismatched++;
            $display("FAIL equal_data: big=%h small=%h exp=%h ds=%b required 4000000/4000000/7f/0",
                     bigFract, smallFract, expAligned, diferenSigns);
        end
        releaseOp();
        nCompared++;
        if (outValid !== 1'b0 || inReady !== 1'b1) begin
            nMismatched++;
            $display("FAIL equal_release: out_valid=%b in_ready=%b required 0/1", outValid, inReady);
        end
    endtask

    task automatic test_shift_one();
        int lat;
        runOp(32'h3F800000, 32'h3F000000, lat);
        nCompared++;
        if (lat !== 3) begin
            nMismatched++;
            $display("FAIL d1_lat: got %0d required 3", lat);
        end
        nCompared++;
        if (bigFract !== 27'h4000000 || smallFract !== 27'h2000000 || expAligned !== 8'h7F) begin
            nMismatched++;
            $display("FAIL d1_data: big=%h small=%h exp=%h required 4000000/2000000/7f",
                     bigFract, smallFract, expAligned);
        end
        releaseOp();
    endtask

    task automatic test_sticky();
        int lat;
        runOp(32'h4B800000, 32'h3F800001, lat);
        nCompared++;
        if (lat !== 26) begin
            nMismatched++;
            $display("FAIL d24_lat: got %0d required 26", lat);
        end
        nCompared++;
        if (smallFract !== 27'h0000005 || expAligned !== 8'h97 || bigFract !== 27'h4000000) begin
            nMismatched++;
            $display("FAIL d24_data: small=%h exp=%h big=%h required 0000005/97/4000000",
                     smallFract, expAligned, bigFract);
        end
        releaseOp();
    endtask

    task automatic test_far();
        int lat;
        runOp(32'h3F800000, 32'h2B800000, lat);
        nCompared++;
        if (lat !== 3) begin
            nMismatched++;
            $display("FAIL d40_lat: got %0d required 3", lat);
        end
        nCompared++;
        if (smallFract !== 27'h0000001 || expAligned !== 8'h7F) begin
            nMismatched++;
            $display("FAIL d40_data: small=%h exp=%h required 0000001/7f", smallFract, expAligned);
        end
        releaseOp();
    endtask

    task automatic test_swap();
        int lat;
        runOp(32'hBF000000, 32'h3F800000, lat);
        nCompared++;
        if (bigFract !== 27'h4000000 || smallFract !== 27'h2000000 || bigSign !== 1'b0
            || diferenSigns !== 1'b1 || expAligned !== 8'h7F) begin
            nMismatched++;
            $display("FAIL swap_data: big=%h small=%h bs=%b ds=%b exp=%h required 4000000/2000000/0/1/7f",
                     bigFract, smallFract, bigSign, diferenSigns, expAligned);
        end
        releaseOp();
    endtask

    task automatic test_zero_special();
        int lat;
        runOp(32'h00000000, 32'h80000000, lat);
        nCompared++;
        if (lat !== 2 || bigFract !== 27'h0 || smallFract !== 27'h0 || expAligned !== 8'h00
            || diferenSigns !== 1'b1) begin
            nMismatched++;
            $display("FAIL zero_data: lat=%0d big=%h small=%h exp=%h ds=%b required 2/0/0/00/1",
                     lat, bigFract, smallFract, expAligned, diferenSigns);
        end
        releaseOp();
        runOp(32'h7F800000, 32'h3F800000, lat);
        nCompared++;
        if (lat !== 3 || special !== 1'b1 || expAligned !== 8'hFF || smallFract !== 27'h0000001) begin
            nMismatched++;
            $display("FAIL special_data: lat=%0d sp=%b exp=%h small=%h required 3/1/ff/0000001",
                     lat, special, expAligned, smallFract);
        end
        releaseOp();
    endtask

    task automatic test_step4();
        int lat;
        runOp4(32'h4B800000, 32'h3F800001, lat);
        nCompared++;
        if (lat !== 8 || smallFract4 !== 27'h0000005 || expAligned4 !== 8'h97) begin
            nMismatched++;
            $display("FAIL step4_d24: lat=%0d small=%h exp=%h required 8/0000005/97",
                     lat, smallFract4, expAligned4);
        end
        @(negedge clk);
        outReady4 = 1'b1;
        @(posedge clk);
        #1;
        outReady4 = 1'b0;
        runOp4(32'h41000000, 32'h3F800000, lat);
        nCompared++;
        if (lat !== 3 || smallFract4 !== 27'h0800000 || expAligned4 !== 8'h82) begin
            nMismatched++;
            $display("FAIL step4_d3: lat=%0d small=%h exp=%h required 3/0800000/82",
                     lat, smallFract4, expAligned4);
        end
        @(negedge clk);
        outReady4 = 1'b1;
        @(posedge clk);
        #1;
        outReady4 = 1'b0;
    endtask

    task automatic test_stall();
        int lat;
        runOp(32'h3F800000, 32'h3F000000, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            nCompared++;
            if (outValid !== 1'b1 || bigFract !== 27'h4000000 || smallFract !== 27'h2000000
                || expAligned !== 8'h7F) begin
                nMismatched++;
                $display("FAIL stall_hold[%0d]: ov=%b big=%h small=%h exp=%h required 1/4000000/2000000/7f",
                         i, outValid, bigFract, smallFract, expAligned);
            end
        end
        releaseOp();
    endtask

    task automatic test_abort();
        int lat;
        @(negedge clk);
        opA = 32'h4B800000;
        opB = 32'h3F800001;
        inValid = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        nCompared++;
        if (outValid !== 1'b0 || inReady !== 1'b1 || stateDbg !== 2'd0) begin
            nMismatched++;
            $display("FAIL abort: ov=%b ir=%b state=%0d required 0/1/0", outValid, inReady, stateDbg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Back-to-back operations after the abort must behave normally.
        runOp(32'h3F800000, 32'h3F000000, lat);
        nCompared++;
        if (lat !== 3 || smallFract !== 27'h2000000) begin
            nMismatched++;
            $display("FAIL post_abort: lat=%0d small=%h required 3/2000000", lat, smallFract);
        end
        releaseOp();
        runOp(32'h3F800000, 32'h3F800000, lat);
        nCompared++;
        if (lat !== 2 || smallFract !== 27'h4000000) begin
            nMismatched++;
            $display("FAIL back_to_back: lat=%0d small=%h required 2/4000000", lat, smallFract);
        end
        releaseOp();
    endtask

    initial begin
        nCompared = 0;
        nMismatched = 0;
        inValid = 1'b0; outReady = 1'b0; opA = '0; opB = '0;
        inValid4 = 1'b0; outReady4 = 1'b0; opA4 = '0; opB4 = '0;
        test_reset();
        test_equal();
        test_shift_one();
        test_sticky();
        test_far();
        test_swap();
        test_zero_special();
        test_step4();
        test_stall();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
